// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ
// valid/ready requesters, granting bursts of up to MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_afull,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     gidx_reg, gidx_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    cand_valid;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;

  // cand_idx[k] is the requester k places after rr_ptr; wrap is explicit so
  // non-power-of-2 NUM_REQ never indexes past the last requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDX_W:0] sum;
      assign data_arr[gi]   = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sum            = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi]   = (sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                              : sum[IDX_W-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Descending scan: the smallest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    gidx_next     = gidx_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_wr_data  = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found && !fifo_afull && !fifo_full) begin
          state_next    = BURST;
          grant_next    = NUM_REQ'(1) << pick_idx;
          gidx_next     = pick_idx;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        req_ready[gidx_reg] = !fifo_full;
        fifo_wr_en          = req_valid[gidx_reg] && !fifo_full;
        if (fifo_wr_en) begin
          fifo_wr_data  = data_arr[gidx_reg];
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        // A dropped valid ends the burst even while the FIFO is full.
        if (!req_valid[gidx_reg] ||
            (fifo_wr_en && beat_cnt_reg == CNT_W'(MAX_BURST - 1))) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (gidx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      gidx_reg     <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      gidx_reg     <= gidx_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign grant = grant_reg;
  assign busy  = (state_reg == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected FIFO writes are queued as
// stimulus is set up and popped whenever the arbiter asserts fifo_wr_en.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_afull;
  logic        fifo_wr_en;
  logic [3:0]  fifo_wr_data;
  logic [3:0]  grant;
  logic        busy;

  logic [3:0]  dval [4];
  logic [3:0]  acc;

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req_data = {dval[3], dval[2], dval[1], dval[0]};

  fifo_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    q.push_back(e);
  endtask

  // Sample on the falling edge; every write must match the head of the queue.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    acc = req_ready & req_valid;
    chk("wr_gate", 32'(fifo_wr_en & (fifo_full | ~busy)), 0);
    chk("beat_eq_write", 32'(|acc), 32'(fifo_wr_en));
    if (fifo_wr_en) begin
      chk("write_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_grant", 32'(grant), 32'(e.g));
        chk("wr_data", 32'(fifo_wr_data), 32'(e.d));
      end
    end
  endtask

  // Requesters advance to their next beat after each accepted handshake.
  task automatic adv();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) dval[i] = dval[i] + 4'd1;
    end
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    acc        = '0;
    for (int i = 0; i < 4; i++) dval[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr_data", 32'(fifo_wr_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1) single requester streams 6 beats: burst of 4, idle gap, burst of 2
    req_valid = 4'b0001;
    dval[0]   = 4'd1;
    for (int i = 1; i <= 6; i++) push(4'b0001, 4'(i));
    sample(); chk("t1_idle_grant", 32'(grant), 0); adv();
    for (int i = 0; i < 4; i++) cyc();
    sample(); chk("t1_gap_busy", 32'(busy), 0); adv();
    sample(); chk("t1_regrant", 32'(grant), 32'(4'b0001)); adv();
    cyc();
    req_valid = 4'b0000;
    cyc();
    cyc();
    chk("t1_q_empty", 32'(q.size()), 0);

    // 2) all requesters valid: grants rotate, 4 writes per burst
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) dval[i] = 4'(i * 4);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++)
        push(4'b0001 << (b % 4), 4'(((b % 4) * 4) + ((b == 4) ? 4 : 0) + k));
    end
    for (int b = 0; b < 5; b++) begin
      sample(); chk("t2_gap_busy", 32'(busy), 0); adv();
      for (int k = 0; k < 4; k++) cyc();
    end
    req_valid = 4'b0000;
    cyc();
    chk("t2_q_empty", 32'(q.size()), 0);

    // 3) fifo_full for 3 cycles after 2 beats stalls the burst
    do_reset();
    req_valid = 4'b0001;
    dval[0]   = 4'd1;
    for (int i = 1; i <= 4; i++) push(4'b0001, 4'(i));
    sample(); chk("t3_idle_grant", 32'(grant), 0); adv();
    cyc();
    cyc();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t3_full_wr_en", 32'(fifo_wr_en), 0);
      chk("t3_full_ready", 32'(req_ready), 0);
      chk("t3_full_grant", 32'(grant), 32'(4'b0001));
      adv();
    end
    fifo_full = 1'b0;
    cyc();
    cyc();
    req_valid = 4'b0000;
    sample(); chk("t3_end_busy", 32'(busy), 0); adv();
    chk("t3_q_empty", 32'(q.size()), 0);

    // 4) fifo_afull blocks a grant in IDLE until it falls
    do_reset();
    fifo_afull = 1'b1;
    req_valid  = 4'b0100;
    dval[2]    = 4'd9;
    push(4'b0100, 4'd9);
    sample(); chk("t4_afull_grant0", 32'(grant), 0); adv();
    sample(); chk("t4_afull_grant1", 32'(grant), 0); adv();
    fifo_afull = 1'b0;
    sample(); chk("t4_release_grant", 32'(grant), 0); adv();
    sample(); chk("t4_grant", 32'(grant), 32'(4'b0100)); adv();

    // 5) granted requester drops valid after 1 beat; pointer moves past it
    req_valid = 4'b0000;
    sample();
    chk("t5_drop_busy", 32'(busy), 1);
    chk("t5_drop_wr_en", 32'(fifo_wr_en), 0);
    adv();
    req_valid = 4'b0101;
    dval[0]   = 4'd3;
    push(4'b0001, 4'd3);
    sample(); chk("t5_idle_busy", 32'(busy), 0); adv();
    sample(); chk("t5_rr_grant", 32'(grant), 32'(4'b0001)); adv();
    req_valid = 4'b0000;
    cyc();

    // 6) reset mid-burst clears outputs at once and restores requester 0 priority
    req_valid = 4'b0010;
    dval[1]   = 4'd5;
    push(4'b0010, 4'd5);
    push(4'b0010, 4'd6);
    sample(); chk("t6_idle_grant", 32'(grant), 0); adv();
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_wr_en", 32'(fifo_wr_en), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0011;
    dval[0]   = 4'd7;
    push(4'b0001, 4'd7);
    sample(); chk("t6_post_idle", 32'(grant), 0); adv();
    sample(); chk("t6_prio_grant", 32'(grant), 32'(4'b0001)); adv();
    req_valid = 4'b0000;
    cyc();
    cyc();
    chk("final_q_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
